// File: rtl/sm83_mem_responder.sv
// Byte-wide RAM bus target for the sm83 CPU bus: decodes a window, inserts wait states, handshakes on mem_rdy.
// Optional feature macro: MEM_ROM_LOCK_EN makes indices below ROM_BYTES read-only.
module sm83_mem_responder #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_STATES = 1,
  parameter int          ROM_BYTES   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        mem_cs,
  input  logic        mem_oe,
  input  logic        mem_we,
  output logic [7:0]  rdata,
  output logic        data_oe,
  output logic        mem_rdy,
  output logic        bus_err
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
`ifdef MEM_ROM_LOCK_EN
  localparam bit ROM_LOCK = 1'b1;
`else
  localparam bit ROM_LOCK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RD_HOLD = 3'd2,
    S_WR_DONE = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    is_wr_q, is_wr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    data_oe_q, data_oe_d;
  logic                    mem_rdy_q, mem_rdy_d;
  logic                    bus_err_q, bus_err_d;
  logic                    wr_en_s;
  logic                    complete_s;
  logic [16:0]             off_s;
  logic                    hit_s;
  logic [7:0]              mem_q [DEPTH];

  // An address below the base wraps to >= 2**16 here, so one compare covers both window edges.
  assign off_s = {1'b0, addr} - {1'b0, ADDR_BASE};
  assign hit_s = mem_cs && (off_s < 17'(DEPTH));

  // Next-state, latched request and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    is_wr_d    = is_wr_q;
    wdata_d    = wdata_q;
    rdata_d    = 8'h00;
    data_oe_d  = 1'b0;
    mem_rdy_d  = 1'b0;
    bus_err_d  = 1'b0;
    wr_en_s    = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit_s && mem_oe && mem_we) begin
          bus_err_d = 1'b1;
        end else if (hit_s && (mem_oe || mem_we)) begin
          idx_d   = off_s[DEPTH_LOG2-1:0];
          is_wr_d = mem_we;
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            complete_s = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!mem_cs || (is_wr_q ? !mem_we : !mem_oe)) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          complete_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RD_HOLD: begin
        if (mem_cs && mem_oe) begin
          rdata_d   = mem_q[idx_q];
          data_oe_d = 1'b1;
          mem_rdy_d = 1'b1;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_WR_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!mem_oe && !mem_we) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // The write lands on the edge that enters WR_DONE, so a following read sees it.
    if (complete_s) begin
      cnt_d     = 4'd0;
      mem_rdy_d = 1'b1;
      if (is_wr_d) begin
        state_d = S_WR_DONE;
        if (ROM_LOCK && (32'(idx_d) < 32'(ROM_BYTES))) begin
          bus_err_d = 1'b1;
        end else begin
          wr_en_s = 1'b1;
        end
      end else begin
        state_d   = S_RD_HOLD;
        rdata_d   = mem_q[idx_d];
        data_oe_d = 1'b1;
      end
    end else begin
      complete_s = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      is_wr_q   <= 1'b0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      data_oe_q <= 1'b0;
      mem_rdy_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      is_wr_q   <= is_wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      data_oe_q <= data_oe_d;
      mem_rdy_q <= mem_rdy_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign data_oe = data_oe_q;
  assign mem_rdy = mem_rdy_q;
  assign bus_err = bus_err_q;

endmodule
